mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
Memory access sequencer between the MAR/MDR pair and the CPU's word-addressed main memory (internal synchronous RAM).
- Takes read/write requests from the control unit, inserts a configurable number of wait states and performs the RAM access.
- On a read, drives the fetched word onto mdata_in, together with MDR select/load strobes, so the MDR captures memory data at the next edge.
- This block is the source of the MDR's memory-data input.

Parameters:
DATA_W, 32, word width (matches MDR/bus).
ADDR_W, 9, address width taken from MAR.
DEPTH, 512, number of RAM words.
WAIT_CYCLES, 1, wait states before the RAM access (0..15).

Ports:
clock  input  1  system clock; all state updates on rising edge.
clear  input  1  reset: asynchronous, active-low (0 = reset).
mar_q  input  ADDR_W  address from MAR.
mdr_q  input  DATA_W  write data from MDR.
read_req  input  1  request memory read (level).
write_req  input  1  request memory write (level).
mdata_in  output  DATA_W  registered read data, to MDR memory-data input.
mdr_read  output  1  MDR input select: 1 = take mdata_in.
mdr_en  output  1  MDR load enable.
busy  output  1  access in progress (state != IDLE).
done  output  1  one-cycle completion pulse.
err  output  1  out-of-range access flag (see Optional Feature).

Behaviour:
- Reset (clear=0, any time, including mid-access): state=IDLE; mdata_in=0; mdr_read, mdr_en, busy, done, err=0. An in-flight write is abandoned and not performed. RAM contents are not cleared.
- FSM states and transitions:
  - IDLE: sample requests.
    - read_req=1 takes priority over write_req when both are 1.
    - Latch mar_q, and latch mdr_q for writes.
    - Load wait counter with WAIT_CYCLES.
    - Go to WAIT, or straight to ACCESS if WAIT_CYCLES=0.
  - WAIT: if counter==1 go to ACCESS, else decrement.
  - ACCESS: on the leaving edge, either write mem[addr]<=data, or set mdata_in<=mem[addr]. Go to DONE.
  - DONE: done=1 for exactly one cycle. For a read, also mdr_read=1 and mdr_en=1 in that same cycle. Go to IDLE.
- Latency: request sampled at edge 0 -> done high after edge WAIT_CYCLES+2 -> IDLE after edge WAIT_CYCLES+3. The next request is accepted no earlier than that edge.
- Request handling:
  - Requests are sampled only in IDLE; requests while busy are ignored, not queued.
  - Requester must drop read_req/write_req during the DONE cycle. A level still held in IDLE starts a new access.
  - mar_q/mdr_q changes after the accept edge have no effect on the current access.
- mdata_in holds its value until the next read completes; writes never change it.
- mdr_read and mdr_en are 0 outside the DONE cycle of a read, so the MDR keeps its bus-load path.

Optional Feature:
MEM_RANGE_CHECK_EN
- Defined: latched address >= DEPTH is out of range.
  - The write is suppressed; a read returns mdata_in=0.
  - err=1 for the DONE cycle only.
  - Timing is unchanged; DEPTH may be less than 2**ADDR_W.
- Undefined: no check is made and err is tied to 0. DEPTH must equal 2**ADDR_W, so every address is valid.

Decomposition:
- Shared constants include (cpu_defs.vh): DATA_W default and the state encodings IDLE/WAIT/ACCESS/DONE (2-bit).
- One sub-module: mem_array. It is a single-port synchronous RAM with clock, we, addr, wdata and registered rdata, no reset, and is parameterised by DATA_W/DEPTH.
- mem_ctrl holds the FSM, wait counter, address/data latches and strobe generation.

Test Plan:
1. Write then read: write_req with mar_q=5, mdr_q=32'hDEADBEEF, WAIT_CYCLES=1. Then read_req at addr 5 -> mdata_in=32'hDEADBEEF, with done, mdr_read and mdr_en high together one cycle, 3 edges after accept.
2. Simultaneous read_req=1 and write_req=1 at addr 7, which holds 32'h4 -> read is performed, mem[7] is unchanged, mdata_in=32'h4.
3. Request while busy: pulse write_req (addr 9, data 32'h1) during WAIT of a read at addr 3 -> ignored. A later read at addr 9 returns the old value; busy stays high throughout the first access.
4. Wait-state sweep with WAIT_CYCLES=0 and WAIT_CYCLES=3 -> done after edges 2 and 5 respectively; each done lasts one cycle.
5. Reset mid-write: clear=0 in WAIT of a write (addr 2, data 32'hFF) -> outputs go to 0 immediately and state is IDLE. A subsequent read of addr 2 returns the prior contents, not 32'hFF.
6. With MEM_RANGE_CHECK_EN, DEPTH=256: write to addr 300 -> err=1 in the DONE cycle, no RAM change. Read from addr 300 -> mdata_in=0, err=1.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: default word width,
// wait-counter width and the 2-bit FSM state encoding.
package mem_ctrl_pkg;

    localparam int DATA_W_DEFAULT = 32;
    localparam int WAIT_W         = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_ctrl_mem_array.sv
// Single-port synchronous RAM with registered read data and no reset.
// The read is read-before-write: a write in the same cycle does not appear on rdata.
module mem_array
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 512,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Synchronous write and registered read at the same address
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory access sequencer between MAR/MDR and word-addressed main memory.
// Accepts read/write requests in IDLE, waits WAIT_CYCLES, performs the RAM
// access and pulses done (plus MDR select/load strobes for reads).
// Optional build macro: MEM_RANGE_CHECK_EN enables the out-of-range check
// (addresses >= DEPTH suppress writes, read back as 0 and raise err).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] mar_q,
    input  logic [DATA_W-1:0] mdr_q,
    input  logic              read_req,
    input  logic              write_req,
    output logic [DATA_W-1:0] mdata_in,
    output logic              mdr_read,
    output logic              mdr_en,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                RAM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    // ACCESS spans two cycles: the first lets the RAM register the latched
    // address, the second (leaving) edge captures rdata / commits the write.
    logic                phase;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                is_write;
    logic                in_range;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_rdata;

`ifdef MEM_RANGE_CHECK_EN
    assign in_range = ({1'b0, addr_q} < (ADDR_W + 1)'(DEPTH));
`else
    assign in_range = 1'b1;
`endif

    assign ram_we = (state == S_ACCESS) && phase && is_write && in_range;
    assign busy   = (state != S_IDLE);

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_mem (
        .clk   (clock),
        .we    (ram_we),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    // Access FSM with wait counter, request latches and registered strobes
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            phase    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            is_write <= 1'b0;
            mdata_in <= '0;
            mdr_read <= 1'b0;
            mdr_en   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done     <= 1'b0;
            mdr_read <= 1'b0;
            mdr_en   <= 1'b0;
            err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (read_req || write_req) begin
                        addr_q   <= mar_q;
                        is_write <= !read_req;
                        if (!read_req) begin
                            data_q <= mdr_q;
                        end
                        wait_cnt <= WAIT_LOAD;
                        phase    <= 1'b0;
                        state    <= (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_W'(1)) begin
                        state <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                    end
                end
                S_ACCESS: begin
                    if (!phase) begin
                        phase <= 1'b1;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        err   <= !in_range;
                        if (!is_write) begin
                            mdata_in <= in_range ? ram_rdata : '0;
                            mdr_read <= 1'b1;
                            mdr_en   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: table of transactions across instances with
// WAIT_CYCLES 1, 0 and 3 (and a DEPTH=256 range-checked instance when
// MEM_RANGE_CHECK_EN is defined), plus hand-written busy/reset sequences.
module tb_mem_ctrl;

    typedef struct {
        logic [1:0]  sel;
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [8:0]  mar_q = '0;
    logic [31:0] mdr_q = '0;
    logic [3:0]  rd_req = '0;
    logic [3:0]  wr_req = '0;
    logic [1:0]  sel = '0;

    logic [31:0] md [4];
    logic [3:0]  mrd_v, men_v, busy_v, done_v, err_v;

    logic [31:0] o_md;
    logic        o_mrd, o_men, o_busy, o_done, o_err;

    logic [31:0] mdata_model [4];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    mem_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(1)) dut_w1 (
        .clock(clock), .clear(clear), .mar_q(mar_q), .mdr_q(mdr_q),
        .read_req(rd_req[0]), .write_req(wr_req[0]), .mdata_in(md[0]),
        .mdr_read(mrd_v[0]), .mdr_en(men_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .err(err_v[0]));

    mem_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(0)) dut_w0 (
        .clock(clock), .clear(clear), .mar_q(mar_q), .mdr_q(mdr_q),
        .read_req(rd_req[1]), .write_req(wr_req[1]), .mdata_in(md[1]),
        .mdr_read(mrd_v[1]), .mdr_en(men_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .err(err_v[1]));

    mem_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_CYCLES(3)) dut_w3 (
        .clock(clock), .clear(clear), .mar_q(mar_q), .mdr_q(mdr_q),
        .read_req(rd_req[2]), .write_req(wr_req[2]), .mdata_in(md[2]),
        .mdr_read(mrd_v[2]), .mdr_en(men_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .err(err_v[2]));

`ifdef MEM_RANGE_CHECK_EN
    mem_ctrl #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_CYCLES(1)) dut_rc (
        .clock(clock), .clear(clear), .mar_q(mar_q), .mdr_q(mdr_q),
        .read_req(rd_req[3]), .write_req(wr_req[3]), .mdata_in(md[3]),
        .mdr_read(mrd_v[3]), .mdr_en(men_v[3]), .busy(busy_v[3]),
        .done(done_v[3]), .err(err_v[3]));
`else
    assign md[3]     = '0;
    assign mrd_v[3]  = 1'b0;
    assign men_v[3]  = 1'b0;
    assign busy_v[3] = 1'b0;
    assign done_v[3] = 1'b0;
    assign err_v[3]  = 1'b0;
`endif

    // Observe the instance currently under test
    always_comb begin
        o_md   = md[sel];
        o_mrd  = mrd_v[sel];
        o_men  = men_v[sel];
        o_busy = busy_v[sel];
        o_done = done_v[sel];
        o_err  = err_v[sel];
    end

    function automatic int lat_of(input logic [1:0] s);
        case (s)
            2'd0:    return 3;
            2'd1:    return 2;
            2'd2:    return 5;
            default: return 3;
        endcase
    endfunction

    function automatic vec_t mkv(input logic [1:0] s, input logic rd, input logic wr,
                                 input logic [8:0] a, input logic [31:0] wd,
                                 input logic [31:0] ed, input logic ee);
        vec_t v;
        v.sel = s; v.rd = rd; v.wr = wr; v.addr = a;
        v.wdata = wd; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full access: request for one cycle, then follow it to IDLE
    task automatic run_access(input vec_t v);
        int lat;
        logic [31:0] exp_md;
        lat = lat_of(v.sel);
        @(negedge clock);
        sel         = v.sel;
        mar_q       = v.addr;
        mdr_q       = v.wdata;
        rd_req[v.sel] = v.rd;
        wr_req[v.sel] = v.wr;
        @(negedge clock);
        rd_req = '0;
        wr_req = '0;
        mar_q  = 9'h1FF;
        mdr_q  = 32'h0BAD0BAD;
        check("busy_after_accept", {31'd0, o_busy}, 32'd1);
        check("done_after_accept", {31'd0, o_done}, 32'd0);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clock);
            check("done_timing", {31'd0, o_done}, (k == lat) ? 32'd1 : 32'd0);
            if (k == lat) begin
                exp_md = v.rd ? v.exp_data : mdata_model[v.sel];
                check("mdr_read", {31'd0, o_mrd}, {31'd0, v.rd});
                check("mdr_en", {31'd0, o_men}, {31'd0, v.rd});
                check("err", {31'd0, o_err}, {31'd0, v.exp_err});
                check("mdata_in", o_md, exp_md);
                mdata_model[v.sel] = exp_md;
            end else begin
                check("busy_mid", {31'd0, o_busy}, 32'd1);
                check("strobe_idle", {30'd0, o_mrd, o_men}, 32'd0);
            end
        end
        @(negedge clock);
        check("busy_end", {31'd0, o_busy}, 32'd0);
        check("done_end", {31'd0, o_done}, 32'd0);
        check("mdr_en_end", {31'd0, o_men}, 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        for (int i = 0; i < 4; i++) mdata_model[i] = '0;

        vecs.push_back(mkv(2'd0, 1'b0, 1'b1, 9'd5,  32'hDEADBEEF, 32'h0,        1'b0));
        vecs.push_back(mkv(2'd0, 1'b1, 1'b0, 9'd5,  32'h0,        32'hDEADBEEF, 1'b0));
        vecs.push_back(mkv(2'd0, 1'b0, 1'b1, 9'd7,  32'h4,        32'h0,        1'b0));
        vecs.push_back(mkv(2'd0, 1'b1, 1'b1, 9'd7,  32'h55,       32'h4,        1'b0));
        vecs.push_back(mkv(2'd0, 1'b1, 1'b0, 9'd7,  32'h0,        32'h4,        1'b0));
        vecs.push_back(mkv(2'd0, 1'b0, 1'b1, 9'd9,  32'h12345678, 32'h0,        1'b0));
        vecs.push_back(mkv(2'd0, 1'b0, 1'b1, 9'd3,  32'hCAFE0003, 32'h0,        1'b0));
        vecs.push_back(mkv(2'd0, 1'b0, 1'b1, 9'd2,  32'h000000AB, 32'h0,        1'b0));
        vecs.push_back(mkv(2'd1, 1'b0, 1'b1, 9'd10, 32'h11110000, 32'h0,        1'b0));
        vecs.push_back(mkv(2'd1, 1'b1, 1'b0, 9'd10, 32'h0,        32'h11110000, 1'b0));
        vecs.push_back(mkv(2'd2, 1'b0, 1'b1, 9'd10, 32'h33330000, 32'h0,        1'b0));
        vecs.push_back(mkv(2'd2, 1'b1, 1'b0, 9'd10, 32'h0,        32'h33330000, 1'b0));
`ifdef MEM_RANGE_CHECK_EN
        vecs.push_back(mkv(2'd3, 1'b0, 1'b1, 9'd44,  32'hA5A5A5A5, 32'h0,        1'b0));
        vecs.push_back(mkv(2'd3, 1'b0, 1'b1, 9'd300, 32'hFFFFFFFF, 32'h0,        1'b1));
        vecs.push_back(mkv(2'd3, 1'b1, 1'b0, 9'd44,  32'h0,        32'hA5A5A5A5, 1'b0));
        vecs.push_back(mkv(2'd3, 1'b1, 1'b0, 9'd300, 32'h0,        32'h0,        1'b1));
`endif

        // Reset state
        #12;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_strobes", {29'd0, o_mrd, o_men, o_err}, 32'd0);
        check("rst_mdata", o_md, 32'd0);
        @(negedge clock);
        clear = 1'b1;

        foreach (vecs[i]) run_access(vecs[i]);

        // Write request pulsed while a read is in WAIT is ignored
        @(negedge clock);
        sel = 2'd0; mar_q = 9'd3; rd_req[0] = 1'b1;
        @(negedge clock);
        rd_req[0] = 1'b0;
        check("busy3_e0", {31'd0, o_busy}, 32'd1);
        mar_q = 9'd9; mdr_q = 32'h1; wr_req[0] = 1'b1;
        @(negedge clock);
        wr_req[0] = 1'b0;
        check("busy3_e1", {31'd0, o_busy}, 32'd1);
        check("done3_e1", {31'd0, o_done}, 32'd0);
        @(negedge clock);
        check("busy3_e2", {31'd0, o_busy}, 32'd1);
        check("done3_e2", {31'd0, o_done}, 32'd0);
        @(negedge clock);
        check("done3_e3", {31'd0, o_done}, 32'd1);
        check("busy3_e3", {31'd0, o_busy}, 32'd1);
        check("mdata3", o_md, 32'hCAFE0003);
        mdata_model[0] = 32'hCAFE0003;
        @(negedge clock);
        check("busy3_idle", {31'd0, o_busy}, 32'd0);
        run_access(mkv(2'd0, 1'b1, 1'b0, 9'd9, 32'h0, 32'h12345678, 1'b0));

        // Asynchronous reset during WAIT of a write abandons the write
        @(negedge clock);
        sel = 2'd0; mar_q = 9'd2; mdr_q = 32'hFF; wr_req[0] = 1'b1;
        @(negedge clock);
        wr_req[0] = 1'b0;
        check("busy5_wait", {31'd0, o_busy}, 32'd1);
        #2 clear = 1'b0;
        #1;
        check("busy5_rst", {31'd0, o_busy}, 32'd0);
        check("mdata5_rst", o_md, 32'd0);
        check("strobes5_rst", {28'd0, o_done, o_mrd, o_men, o_err}, 32'd0);
        for (int i = 0; i < 4; i++) mdata_model[i] = '0;
        @(negedge clock);
        clear = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("idle5_after_rst", {31'd0, o_busy}, 32'd0);
        end
        run_access(mkv(2'd0, 1'b1, 1'b0, 9'd2, 32'h0, 32'h000000AB, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
